// File: rtl/ram_access_ctrl_pkg.sv
// Shared state encoding and default widths for the RAM access controller.
package ram_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_CAPT  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_access_ctrl_edge_detect.sv
// Rising-edge detector: 0-cycle latency, no backpressure. History resets high,
// so a level already high at reset release is not seen as an edge.
module edge_detect (
    input  logic clk,
    input  logic clrn,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            prev <= 1'b1;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrates button writes and tick-paced read sweep onto a sync RAM; tick->rd_valid 4 cycles
// when idle, writes win; extra requests while one is pending collapse into one.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              wr_btn,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              scan_en,
    input  logic              tick,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_inaddr,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_outaddr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    state_t            state;
    logic              wr_rise;
    logic              wr_pend;
    logic              rd_pend;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] scan_ptr;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    edge_detect u_wr_edge (
        .clk  (clk),
        .clrn (clrn),
        .in   (wr_btn),
        .rise (wr_rise)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            scan_ptr   <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;

            if (wr_rise) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end

            // A new request arriving in the cycle that retires the old one keeps the flag set.
            if (wr_rise) begin
                wr_pend <= 1'b1;
            end else if (state == WRITE) begin
                wr_pend <= 1'b0;
            end

            if (tick && scan_en) begin
                rd_pend <= 1'b1;
            end else if (state == RD_ISSUE) begin
                rd_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (wr_pend) begin
                        state <= WRITE;
                    end else if (rd_pend) begin
                        state <= RD_ISSUE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                RD_ISSUE: begin
                    state <= RD_CAPT;
                end
                RD_CAPT: begin
                    rd_data_q  <= ram_dout;
                    rd_addr_q  <= scan_ptr;
                    scan_ptr   <= scan_ptr + 1'b1;
                    rd_valid_q <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register so reset drops ram_we asynchronously.
    assign ram_we      = (state == WRITE);
    assign busy        = (state != IDLE);
    assign ram_inaddr  = wr_addr_q;
    assign ram_din     = wr_data_q;
    assign ram_outaddr = scan_ptr;
    assign rd_addr     = rd_addr_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a synchronous RAM model and write/read scoreboards.
module tb_ram_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xact_t;

    logic          clk;
    logic          clrn;
    logic          wr_btn;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          scan_en;
    logic          tick;
    logic          ram_we;
    logic [AW-1:0] ram_inaddr;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_outaddr;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cnt = 0;
    int rv_cnt = 0;
    int we_cyc = 0;
    int rv_cyc = 0;
    logic prev_we = 1'b0;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] shadow [2**AW];
    logic [AW-1:0] sptr;
    xact_t wq[$];
    xact_t rq[$];

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .wr_btn     (wr_btn),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .scan_en    (scan_en),
        .tick       (tick),
        .ram_we     (ram_we),
        .ram_inaddr (ram_inaddr),
        .ram_din    (ram_din),
        .ram_outaddr(ram_outaddr),
        .ram_dout   (ram_dout),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External synchronous RAM: read data appears one cycle after a non-write edge.
    always @(posedge clk) begin
        if (ram_we) mem[ram_inaddr] <= ram_din;
        else        ram_dout <= mem[ram_outaddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        xact_t e;
        if (clrn) begin
            if (ram_we) begin
                we_cnt++;
                we_cyc = cyc;
                chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", {28'd0, ram_inaddr}, {28'd0, e.a});
                    chk("wr_data", {24'd0, ram_din}, {24'd0, e.d});
                end else begin
                    chk("unexpected_write", {31'd0, ram_we}, 32'd0);
                end
            end
            if (rd_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                if (rq.size() > 0) begin
                    e = rq.pop_front();
                    chk("rd_addr", {28'd0, rd_addr}, {28'd0, e.a});
                    chk("rd_data", {24'd0, rd_data}, {24'd0, e.d});
                end else begin
                    chk("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
                end
            end
        end
        prev_we = clrn ? ram_we : 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rd();
        xact_t e;
        e.a = sptr;
        e.d = shadow[sptr];
        rq.push_back(e);
        sptr = sptr + 1'b1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        xact_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
        shadow[a] = d;
    endtask

    task automatic do_tick(input bit expect_rd);
        tick = 1'b1;
        if (expect_rd) push_rd();
        step(1);
        tick = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rd_addr"},     {28'd0, rd_addr},     32'd0);
        chk({pfx, "_rd_data"},     {24'd0, rd_data},     32'd0);
        chk({pfx, "_rd_valid"},    {31'd0, rd_valid},    32'd0);
        chk({pfx, "_ram_we"},      {31'd0, ram_we},      32'd0);
        chk({pfx, "_ram_inaddr"},  {28'd0, ram_inaddr},  32'd0);
        chk({pfx, "_ram_din"},     {24'd0, ram_din},     32'd0);
        chk({pfx, "_ram_outaddr"}, {28'd0, ram_outaddr}, 32'd0);
        chk({pfx, "_busy"},        {31'd0, busy},        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int base;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i]    = 8'(i * 37 + 11);
            shadow[i] = 8'(i * 37 + 11);
        end
        sptr    = '0;
        clrn    = 1'b0;
        wr_btn  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        scan_en = 1'b0;
        tick    = 1'b0;

        // Reset state, with the write button held across release.
        step(3);
        chk_all_zero("reset");
        clrn = 1'b1;
        step(5);
        chk("held_btn_no_write", we_cnt, 0);
        chk("held_btn_idle", {31'd0, busy}, 32'd0);
        wr_btn = 1'b0;
        step(2);

        // Tick with scan disabled is ignored.
        do_tick(1'b0);
        step(6);
        chk("scan_off_no_read", rv_cnt, 0);

        // Sweep: first tick also measures tick-to-rd_valid latency.
        scan_en = 1'b1;
        tick = 1'b1;
        push_rd();
        step(1);
        tick = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                lat = k;
                break;
            end
        end
        chk("tick_latency", lat, 4);
        step(5);
        for (int i = 1; i < 16; i++) begin
            do_tick(1'b1);
            step(7);
        end
        chk("sweep_last_addr", {28'd0, rd_addr}, 32'd15);
        do_tick(1'b1);
        step(7);
        chk("wrap_addr", {28'd0, rd_addr}, 32'd0);
        chk("sweep_count", rv_cnt, 17);

        // Single write, one-cycle write strobe.
        base = we_cnt;
        wr_addr = 4'd5;
        wr_data = 8'hA7;
        wr_btn  = 1'b1;
        push_wr(4'd5, 8'hA7);
        step(1);
        wr_btn = 1'b0;
        step(6);
        chk("write_pulse_count", we_cnt - base, 1);

        // Advance scan to 3, then write 3 and tick together: write must land first.
        do_tick(1'b1);
        step(7);
        do_tick(1'b1);
        step(7);
        chk("ptr_at_3", {28'd0, ram_outaddr}, 32'd3);
        wr_addr = 4'd3;
        wr_data = 8'h3C;
        wr_btn  = 1'b1;
        tick    = 1'b1;
        push_wr(4'd3, 8'h3C);
        push_rd();
        step(1);
        wr_btn = 1'b0;
        tick   = 1'b0;
        step(10);
        chk("same_cycle_rd_addr", {28'd0, rd_addr}, 32'd3);
        chk("same_cycle_rd_data", {24'd0, rd_data}, 32'h3C);
        chk("write_before_read", {31'd0, (rv_cyc > we_cyc)}, 32'd1);

        // Three back-to-back ticks collapse into two reads.
        base = rv_cnt;
        tick = 1'b1;
        push_rd();
        push_rd();
        step(3);
        tick = 1'b0;
        step(15);
        chk("burst_two_reads", rv_cnt - base, 2);

        // Reset pulse during RD_CAPT aborts the read.
        base = rv_cnt;
        do_tick(1'b0);
        step(2);
        chk("in_rd_capt_busy", {31'd0, busy}, 32'd1);
        clrn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        step(1);
        clrn = 1'b1;
        sptr = '0;
        step(8);
        chk("aborted_read_no_valid", rv_cnt - base, 0);
        chk("ptr_after_reset", {28'd0, ram_outaddr}, 32'd0);

        // Sweep resumes from address 0.
        do_tick(1'b1);
        step(8);
        chk("resume_addr", {28'd0, rd_addr}, 32'd0);
        chk("rd_queue_drained", rq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the RAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port clrn, input, 1: reset, asynchronous, active-low.
REQ-005 Port wr_btn, input, 1: debounced write button, level; a rising edge requests one write.
REQ-006 Port wr_addr, input, ADDR_W: write address, sampled on the wr_btn rising edge.
REQ-007 Port wr_data, input, DATA_W: write data, sampled on the wr_btn rising edge.
REQ-008 Port scan_en, input, 1: 1 enables the read sweep.
REQ-009 Port tick, input, 1: one-cycle scan-advance strobe from the clock divider.
REQ-010 Port ram_we, output, 1: RAM write enable.
REQ-011 Port ram_inaddr, output, ADDR_W: RAM write address.
REQ-012 Port ram_din, output, DATA_W: RAM write data.
REQ-013 Port ram_outaddr, output, ADDR_W: RAM read address.
REQ-014 Port ram_dout, input, DATA_W: RAM read data; valid one cycle after a we=0 edge.
REQ-015 Port rd_addr, output, ADDR_W: address of the last captured read.
REQ-016 Port rd_data, output, DATA_W: last captured read data; held until the next capture.
REQ-017 Port rd_valid, output, 1: one-cycle pulse when rd_addr/rd_data update.
REQ-018 Port busy, output, 1: 1 whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, RD_ISSUE, RD_CAPT.
REQ-020 A wr_btn rising edge SHALL set wr_pend and latch wr_addr/wr_data; a later edge while pending overwrites the latch (latest wins).
REQ-021 tick=1 with scan_en=1 SHALL set rd_pend; tick with scan_en=0 is ignored.
REQ-022 IDLE: wr_pend -> WRITE; else rd_pend -> RD_ISSUE; else stay IDLE. Write has priority.
REQ-023 WRITE SHALL last exactly one cycle with ram_we=1, ram_inaddr/ram_din = latched values; clear wr_pend; -> IDLE.
REQ-024 RD_ISSUE SHALL last one cycle with ram_we=0, ram_outaddr=scan_ptr; clear rd_pend; -> RD_CAPT.
REQ-025 RD_CAPT SHALL last one cycle with ram_we=0; at its closing edge rd_data<=ram_dout, rd_addr<=scan_ptr, scan_ptr<=scan_ptr+1; -> IDLE.
REQ-026 rd_valid SHALL be 1 for the single cycle after RD_CAPT; tick-to-rd_valid latency is 4 cycles when idle.
REQ-027 scan_ptr SHALL wrap from 2^ADDR_W-1 to 0.
REQ-028 ram_we SHALL be 1 only in WRITE; ram_outaddr SHALL equal scan_ptr in all other states.
REQ-029 A simultaneous wr_btn edge and tick SHALL set both pending flags; the write completes before the read.
REQ-030 A read of an address written in the same IDLE window SHALL return the new data.
REQ-031 A tick arriving while rd_pend=1 or during RD_ISSUE/RD_CAPT SHALL be kept as a single pending read; extra ticks are dropped.
REQ-032 Setting scan_en=0 SHALL not abort a read already in RD_ISSUE/RD_CAPT.

Reset
REQ-033 clrn=0 SHALL immediately force state=IDLE, scan_ptr=0, wr_pend=0, rd_pend=0, latched addr/data=0.
REQ-034 During reset: rd_addr=0, rd_data=0, rd_valid=0, ram_we=0, ram_inaddr=0, ram_din=0, ram_outaddr=0, busy=0.
REQ-035 The wr_btn edge-detect register SHALL reset to 1, so a button held through reset does not trigger a write.
REQ-036 Reset asserted during WRITE SHALL deassert ram_we asynchronously.

Structure
REQ-037 A shared package SHALL hold the state encoding and the ADDR_W/DATA_W defaults.
REQ-038 Rising-edge detection SHALL be a sub-module named edge_detect (clk, clrn, in, rise).
REQ-039 The RAM SHALL sit outside this block; ram_* ports connect to it directly.

Verification
REQ-040 Reset, scan_en=1, 16 ticks spaced 8 cycles apart -> rd_addr sequence 0..15, then a 17th tick gives rd_addr=0.
REQ-041 wr_btn edge with wr_addr=5, wr_data=8'hA7 -> ram_we=1 for exactly 1 cycle with ram_inaddr=5, ram_din=8'hA7.
REQ-042 wr_btn edge (addr 3, data 8'h3C) and tick in the same cycle with scan_ptr=3 -> WRITE first, then rd_valid with rd_addr=3, rd_data=8'h3C.
REQ-043 Three ticks within 2 cycles while busy -> exactly two rd_valid pulses.
REQ-044 clrn pulsed low during RD_CAPT -> rd_valid never asserts, scan_ptr=0, all outputs 0.
REQ-045 wr_btn held high across reset release -> no write occurs.
